// File: rtl/rom_rd_mport_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_rd_mport_if
// Description : Bundle of per-channel address/data handshakes plus the
//               shared synchronous-ROM port used by rom_rd_mport.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_rd_mport_if #(
  parameter int W_DATA  = 13,
  parameter int W_ADDR  = 12,
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0]                addr_valid;
  logic [N_PORTS-1:0]                addr_ready;
  logic [N_PORTS*W_ADDR-1:0]         addr_data;
  logic [N_PORTS-1:0]                data_valid;
  logic [N_PORTS-1:0]                data_ready;
  logic signed [N_PORTS*W_DATA-1:0]  data;
  logic                              rom_en;
  logic [W_ADDR-1:0]                 rom_addr;
  logic signed [W_DATA-1:0]          rom_data;

  // Environment side: requesters, consumers and the ROM itself.
  modport master (
    output addr_valid, addr_data, data_ready, rom_data,
    input  addr_ready, data_valid, data, rom_en, rom_addr
  );

  modport slave (
    input  addr_valid, addr_data, data_ready, rom_data,
    output addr_ready, data_valid, data, rom_en, rom_addr
  );
endinterface
`default_nettype wire

// File: rtl/rom_rd_mport.sv
`default_nettype none
// ============================================================================
// Module      : rom_rd_mport
// Description : Multi-channel read front end for one synchronous ROM with
//               per-channel credit-checked output buffers. Define
//               ROM_RD_RR_EN for round-robin arbitration (default: fixed
//               priority, lowest channel wins).
// Revision    : 1.0 - initial release
// ============================================================================
module rom_rd_mport #(
  parameter int W_DATA     = 13,
  parameter int W_ADDR     = 12,
  parameter int N_PORTS    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  rom_rd_mport_if.slave  bus
);

  localparam int C_W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int C_W_PTR = $clog2(FIFO_DEPTH);
  localparam int C_W_CNT = $clog2(FIFO_DEPTH + 1) + 1;

  logic                     r_infl_vld_q;
  logic [C_W_IDX-1:0]       r_infl_ch_q;
  logic [C_W_CNT-1:0]       r_cnt_q [N_PORTS];
  logic [C_W_CNT-1:0]       r_cnt_d [N_PORTS];
  logic [C_W_PTR-1:0]       r_wr_q  [N_PORTS];
  logic [C_W_PTR-1:0]       r_wr_d  [N_PORTS];
  logic [C_W_PTR-1:0]       r_rd_q  [N_PORTS];
  logic [C_W_PTR-1:0]       r_rd_d  [N_PORTS];
  logic signed [W_DATA-1:0] r_mem_q [N_PORTS][FIFO_DEPTH];

  logic [N_PORTS-1:0]        w_push;
  logic [N_PORTS-1:0]        w_pop;
  logic [N_PORTS-1:0]        w_dv;
  logic [N_PORTS-1:0]        w_elig;
  logic [C_W_CNT-1:0]        w_credit [N_PORTS];
  logic [N_PORTS*W_DATA-1:0] w_data;
  logic [N_PORTS-1:0]        w_addr_ready;
  logic [W_ADDR-1:0]         w_rom_addr;
  logic                      w_grant_vld;
  logic [C_W_IDX-1:0]        w_grant_idx;

  function automatic logic [C_W_PTR-1:0] ptr_inc(input logic [C_W_PTR-1:0] p);
    return (p == C_W_PTR'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts the buffered words plus the single read still in the ROM.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    w_dv   = '0;
    w_elig = '0;
    w_data = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_push[i]   = r_infl_vld_q && (r_infl_ch_q == C_W_IDX'(i));
      w_dv[i]     = (r_cnt_q[i] != '0);
      w_pop[i]    = w_dv[i] && bus.data_ready[i];
      w_credit[i] = r_cnt_q[i] + C_W_CNT'(w_push[i]);
      w_elig[i]   = bus.addr_valid[i] &&
                    ((w_credit[i] - C_W_CNT'(w_pop[i])) < C_W_CNT'(FIFO_DEPTH));
      r_cnt_d[i]  = r_cnt_q[i] + C_W_CNT'(w_push[i]) - C_W_CNT'(w_pop[i]);
      r_wr_d[i]   = w_push[i] ? ptr_inc(r_wr_q[i]) : r_wr_q[i];
      r_rd_d[i]   = w_pop[i]  ? ptr_inc(r_rd_q[i]) : r_rd_q[i];
      w_data[i*W_DATA +: W_DATA] = w_dv[i] ? r_mem_q[i][r_rd_q[i]] : '0;
    end
  end

`ifdef ROM_RD_RR_EN
  logic [C_W_IDX-1:0] r_rr_q;
  logic [C_W_IDX-1:0] r_rr_d;

  // Scan downward so the candidate nearest the pointer is the final winner.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (rst) begin
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        int j;
        j = int'(r_rr_q) + k;
        if (j >= N_PORTS) j = j - N_PORTS;
        if (w_elig[j]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = C_W_IDX'(j);
        end
      end
    end
    r_rr_d = (w_grant_idx == C_W_IDX'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_q <= '0;
    end else if (w_grant_vld) begin
      r_rr_q <= r_rr_d;
    end
  end
`else
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (rst) begin
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        if (w_elig[k]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = C_W_IDX'(k);
        end
      end
    end
  end
`endif

  always_comb begin
    w_addr_ready = '0;
    w_rom_addr   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_grant_vld && (w_grant_idx == C_W_IDX'(i))) begin
        w_addr_ready[i] = 1'b1;
        w_rom_addr      = bus.addr_data[i*W_ADDR +: W_ADDR];
      end
    end
  end

  assign bus.addr_ready = w_addr_ready;
  assign bus.rom_en     = w_grant_vld;
  assign bus.rom_addr   = w_rom_addr;
  assign bus.data_valid = w_dv;
  assign bus.data       = w_data;

  // rom_data belongs to the read issued last cycle; the tag routes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_infl_vld_q <= 1'b0;
      r_infl_ch_q  <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        r_cnt_q[i] <= '0;
        r_wr_q[i]  <= '0;
        r_rd_q[i]  <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          r_mem_q[i][j] <= '0;
        end
      end
    end else begin
      r_infl_vld_q <= w_grant_vld;
      r_infl_ch_q  <= w_grant_idx;
      for (int i = 0; i < N_PORTS; i++) begin
        r_cnt_q[i] <= r_cnt_d[i];
        r_wr_q[i]  <= r_wr_d[i];
        r_rd_q[i]  <= r_rd_d[i];
        if (w_push[i]) begin
          r_mem_q[i][r_wr_q[i]] <= bus.rom_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_rd_mport.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_rd_mport
// Description : Self-checking bench for rom_rd_mport: directed vector table,
//               reset/arbitration sequences and a randomized run against a
//               queue-based reference model. Honours ROM_RD_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_rd_mport;

  localparam int W_DATA     = 13;
  localparam int W_ADDR     = 12;
  localparam int N_PORTS    = 2;
  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rom_rd_mport_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_PORTS(N_PORTS)) bus ();

  rom_rd_mport #(
    .W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_PORTS(N_PORTS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W_DATA-1:0] rom_fn(input logic [W_ADDR-1:0] a);
    if (a == 12'h0FF) return '1;
    return W_DATA'(int'(a) + 100);
  endfunction

  // Synchronous ROM: word appears the cycle after rom_en.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_addr);
  end

  typedef struct {
    logic [1:0]        av;
    logic [W_ADDR-1:0] a0, a1;
    logic [1:0]        rdy;
    logic [1:0]        ardy;
    logic              en;
    logic [W_ADDR-1:0] raddr;
    logic [1:0]        dv;
    logic [W_DATA-1:0] d0, d1;
  } vec_t;

  typedef struct {
    int                ch;
    logic [W_DATA-1:0] v;
    int                t;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  int   rr;
  int   cyc;

  function automatic vec_t mk(input logic [1:0] av, input int a0, input int a1,
                              input logic [1:0] rdy, input logic [1:0] ardy,
                              input logic en, input int raddr, input logic [1:0] dv,
                              input int d0, input int d1);
    vec_t v;
    v.av = av; v.a0 = W_ADDR'(a0); v.a1 = W_ADDR'(a1); v.rdy = rdy;
    v.ardy = ardy; v.en = en; v.raddr = W_ADDR'(raddr); v.dv = dv;
    v.d0 = W_DATA'(d0); v.d1 = W_DATA'(d1);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] av, input logic [W_ADDR-1:0] a0,
                       input logic [W_ADDR-1:0] a1, input logic [1:0] rdy);
    bus.addr_valid = av;
    bus.addr_data  = {a1, a0};
    bus.data_ready = rdy;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_ardy"}, 32'(bus.addr_ready), 0);
    check({nm, "_en"},   32'(bus.rom_en), 0);
    check({nm, "_raddr"},32'(bus.rom_addr), 0);
    check({nm, "_dv"},   32'(bus.data_valid), 0);
    check({nm, "_data"}, 32'(bus.data), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 12'h011, 12'h022, 2'b11);
    #1 check_idle_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, '0, '0, 2'b11);
    mq.delete();
    rr  = 0;
    cyc = 0;
  endtask

  initial begin
    logic [1:0]        av, rdy, eardy, edv;
    logic [W_ADDR-1:0] a0, a1, eaddr;
    logic [W_DATA-1:0] ed [2];
    int                hidx [2];
    int                cntc [2];
    logic [1:0]        elig, pp;
    int                g;

    // Short bursts, a stalled channel beside a live one, and a signed word.
    tbl.push_back(mk(2'b01, 0, 0, 2'b11, 2'b01, 1, 0, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 1, 0, 2'b11, 2'b01, 1, 1, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 2, 0, 2'b11, 2'b01, 1, 2, 2'b01, 100, 0));
    tbl.push_back(mk(2'b01, 3, 0, 2'b11, 2'b01, 1, 3, 2'b01, 101, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b01, 102, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b01, 103, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 5, 0, 2'b10, 2'b01, 1, 5, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 6, 0, 2'b10, 2'b01, 1, 6, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 7, 10, 2'b10, 2'b10, 1, 10, 2'b01, 105, 0));
    tbl.push_back(mk(2'b11, 7, 11, 2'b10, 2'b10, 1, 11, 2'b01, 105, 0));
    tbl.push_back(mk(2'b11, 7, 12, 2'b10, 2'b10, 1, 12, 2'b11, 105, 110));
    tbl.push_back(mk(2'b01, 7, 0, 2'b10, 2'b00, 0, 0, 2'b11, 105, 111));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b11, 105, 112));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b01, 106, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 'h0FF, 0, 2'b11, 2'b01, 1, 'h0FF, 2'b00, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b01, 'h1FFF, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0));

    rst = 1'b0;
    drive(2'b11, 12'h001, 12'h002, 2'b11);
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, '0, '0, 2'b11);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].a0, tbl[i].a1, tbl[i].rdy);
      #1;
      check($sformatf("tbl%0d_ardy", i),  32'(bus.addr_ready), 32'(tbl[i].ardy));
      check($sformatf("tbl%0d_en", i),    32'(bus.rom_en),     32'(tbl[i].en));
      check($sformatf("tbl%0d_raddr", i), 32'(bus.rom_addr),   32'(tbl[i].raddr));
      check($sformatf("tbl%0d_dv", i),    32'(bus.data_valid), 32'(tbl[i].dv));
      check($sformatf("tbl%0d_d0", i),    32'(bus.data[W_DATA-1:0]), 32'(tbl[i].d0));
      check($sformatf("tbl%0d_d1", i),    32'(bus.data[2*W_DATA-1:W_DATA]), 32'(tbl[i].d1));
    end

    // Both channels permanently requesting.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(2'b11, W_ADDR'(k), W_ADDR'(12'h200 + k), 2'b11);
      #1;
`ifdef ROM_RD_RR_EN
      eardy = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      eardy = 2'b01;
`endif
      check($sformatf("arb%0d_ardy", k), 32'(bus.addr_ready), 32'(eardy));
      check($sformatf("arb%0d_raddr", k), 32'(bus.rom_addr),
            (eardy == 2'b01) ? k : 32'h200 + k);
    end
    repeat (4) begin
      @(negedge clk);
      drive(2'b00, '0, '0, 2'b11);
    end

    // Reset lands while a read is in flight.
    @(negedge clk);
    drive(2'b01, 12'd3, 12'd0, 2'b11);
    #1 check("mid_issue_ardy", 32'(bus.addr_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, '0, '0, 2'b11);
    #1 check_idle_outputs("mid_rst");
    repeat (2) begin
      @(negedge clk);
      #1 check("mid_rst_dv", 32'(bus.data_valid), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 12'd9, 12'd20, 2'b11);
    #1;
    check("post_rst_ardy", 32'(bus.addr_ready), 32'h1);
    check("post_rst_raddr", 32'(bus.rom_addr), 32'd9);
    @(negedge clk);
    drive(2'b00, '0, '0, 2'b11);
    #1 check("post_rst_dv1", 32'(bus.data_valid), 0);
    @(negedge clk);
    #1;
    check("post_rst_dv2", 32'(bus.data_valid), 32'h1);
    check("post_rst_d0", 32'(bus.data[W_DATA-1:0]), 32'd109);
    @(negedge clk);
    #1 check("post_rst_dv3", 32'(bus.data_valid), 0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      av     = 2'($urandom);
      a0     = W_ADDR'($urandom);
      a1     = W_ADDR'($urandom);
      rdy[0] = ($urandom_range(0, 3) != 0);
      rdy[1] = ($urandom_range(0, 3) != 0);
      drive(av, a0, a1, rdy);
      #1;
      for (int i = 0; i < 2; i++) begin
        hidx[i] = -1;
        cntc[i] = 0;
        foreach (mq[j]) begin
          if (mq[j].ch == i) begin
            cntc[i]++;
            if (hidx[i] < 0) hidx[i] = j;
          end
        end
        edv[i]  = (hidx[i] >= 0) && (mq[hidx[i]].t <= cyc);
        ed[i]   = edv[i] ? mq[hidx[i]].v : '0;
        pp[i]   = edv[i] && rdy[i];
        elig[i] = av[i] && ((cntc[i] - int'(pp[i])) < FIFO_DEPTH);
      end
      g = -1;
`ifdef ROM_RD_RR_EN
      for (int k = 0; k < N_PORTS; k++) begin
        if (g < 0 && elig[(rr + k) % N_PORTS]) g = (rr + k) % N_PORTS;
      end
`else
      for (int k = 0; k < N_PORTS; k++) begin
        if (g < 0 && elig[k]) g = k;
      end
`endif
      eardy = (g >= 0) ? 2'(1 << g) : 2'b00;
      eaddr = (g == 0) ? a0 : (g == 1) ? a1 : '0;
      check("rnd_ardy",  32'(bus.addr_ready), 32'(eardy));
      check("rnd_en",    32'(bus.rom_en), (g >= 0) ? 1 : 0);
      check("rnd_raddr", 32'(bus.rom_addr), 32'(eaddr));
      check("rnd_dv",    32'(bus.data_valid), 32'(edv));
      check("rnd_d0",    32'(bus.data[W_DATA-1:0]), 32'(ed[0]));
      check("rnd_d1",    32'(bus.data[2*W_DATA-1:W_DATA]), 32'(ed[1]));
      for (int j = mq.size() - 1; j >= 0; j--) begin
        if ((pp[0] && j == hidx[0]) || (pp[1] && j == hidx[1])) mq.delete(j);
      end
      if (g >= 0) begin
        mq.push_back('{ch: g, v: rom_fn(eaddr), t: cyc + 2});
        rr = (g + 1) % N_PORTS;
      end
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
